// File: rtl/morsecode_pkg.sv
// Shared definitions for the Morse letter transmitter: state encoding and
// unit counts for each timed interval.
package morsecode_pkg;

    localparam int unsigned UNITS_W    = 2;
    localparam int unsigned DOT_UNITS  = 1;
    localparam int unsigned DASH_UNITS = 3;
    localparam int unsigned GAP_UNITS  = 1;
    localparam int unsigned LGAP_UNITS = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MARK  = 3'd1,
        ST_SPACE = 3'd2,
        ST_LGAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Mark length in units for one symbol bit (1 = dash, 0 = dot)
    function automatic logic [UNITS_W-1:0] sym_units(input logic is_dash);
        return is_dash ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
    endfunction

endpackage : morsecode_pkg

// File: rtl/morsecode_unit_timer.sv
// Unit timer: prescaler of UNIT_CYCLES clocks feeding a unit down-counter.
// load restarts the interval for 'units' Morse units; expire_c is high in the
// final clock of the interval so the owner can switch state on that edge.
module morsecode_unit_timer
    import morsecode_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [UNITS_W-1:0] units,
    output logic               expire_c
);

    localparam int unsigned PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    logic [PRE_W-1:0]   pre_q,    pre_d;
    logic [UNITS_W-1:0] units_q,  units_d;
    logic               active_q, active_d;

    // Last clock of the last unit of an active interval
    assign expire_c = active_q && (pre_q == '0) && (units_q == '0);

    // Next-state for prescaler and unit counter; load wins over expiry
    always_comb begin
        pre_d    = pre_q;
        units_d  = units_q;
        active_d = active_q;
        if (load) begin
            active_d = 1'b1;
            pre_d    = PRE_W'(UNIT_CYCLES - 1);
            units_d  = units - UNITS_W'(1);
        end else if (active_q) begin
            if (pre_q == '0) begin
                if (units_q == '0) begin
                    active_d = 1'b0;
                end else begin
                    units_d = units_q - UNITS_W'(1);
                    pre_d   = PRE_W'(UNIT_CYCLES - 1);
                end
            end else begin
                pre_d = pre_q - PRE_W'(1);
            end
        end
    end

    // Timer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q    <= '0;
            units_q  <= '0;
            active_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            units_q  <= units_d;
            active_q <= active_d;
        end
    end

endmodule : morsecode_unit_timer

// File: rtl/morsecode_tx_controller.sv
// Morse letter transmitter: latches a dot/dash pattern and length on start,
// then drives morse_out for exact unit-multiple mark/space durations.
// Optional macro MORSE_LETTER_GAP_EN appends a 3-unit low gap (busy held)
// after the last mark so back-to-back letters are correctly spaced.
module morsecode_tx_controller
    import morsecode_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 25_000_000,
    parameter int unsigned MAX_LEN     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         len_in,
    input  logic [MAX_LEN-1:0] pattern_in,
    output logic               morse_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic               morse_out_q, morse_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tmr_load_c;
    logic [UNITS_W-1:0] tmr_units_c;
    logic               tmr_expire_c;
    logic [CNT_W-1:0]   len_clamped_c;

    morsecode_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_c),
        .units    (tmr_units_c),
        .expire_c (tmr_expire_c)
    );

    // Requested length saturated at MAX_LEN
    always_comb begin
        if (32'(len_in) > MAX_LEN) begin
            len_clamped_c = CNT_W'(MAX_LEN);
        end else begin
            len_clamped_c = CNT_W'(len_in);
        end
    end

    // Next-state, symbol bookkeeping and timer control
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pat_d       = pat_q;
        tmr_load_c  = 1'b0;
        tmr_units_c = UNITS_W'(DOT_UNITS);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d = pattern_in;
                    rem_d = len_clamped_c;
                    if (len_clamped_c == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_MARK;
                        tmr_load_c  = 1'b1;
                        tmr_units_c = sym_units(pattern_in[0]);
                    end
                end
            end
            ST_MARK: begin
                if (tmr_expire_c) begin
                    rem_d = rem_q - CNT_W'(1);
                    pat_d = pat_q >> 1;
                    if (rem_q == CNT_W'(1)) begin
`ifdef MORSE_LETTER_GAP_EN
                        state_d     = ST_LGAP;
                        tmr_load_c  = 1'b1;
                        tmr_units_c = UNITS_W'(LGAP_UNITS);
`else
                        state_d     = ST_DONE;
`endif
                    end else begin
                        state_d     = ST_SPACE;
                        tmr_load_c  = 1'b1;
                        tmr_units_c = UNITS_W'(GAP_UNITS);
                    end
                end
            end
            ST_SPACE: begin
                if (tmr_expire_c) begin
                    state_d     = ST_MARK;
                    tmr_load_c  = 1'b1;
                    tmr_units_c = sym_units(pat_q[0]);
                end
            end
            ST_LGAP: begin
                if (tmr_expire_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered images of the next state
    always_comb begin
        morse_out_d = (state_d == ST_MARK);
        busy_d      = (state_d == ST_MARK) || (state_d == ST_SPACE) || (state_d == ST_LGAP);
        done_d      = (state_d == ST_DONE);
    end

    // State, latched letter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            pat_q       <= '0;
            morse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            pat_q       <= pat_d;
            morse_out_q <= morse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign morse_out = morse_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : morsecode_tx_controller

// File: tb/tb_morsecode_tx_controller.sv
// Bench for morsecode_tx_controller (UNIT_CYCLES=4, MAX_LEN=4).
// Each stimulus pushes the expected per-cycle {morse_out,busy,done} trace;
// a negedge monitor pops one entry per clock and compares.
module tb_morsecode_tx_controller;

    localparam int unsigned UNIT = 4;
    localparam int unsigned MLEN = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      len_in;
    logic [MLEN-1:0] pattern_in;
    logic            morse_out;
    logic            busy;
    logic            done;

    logic [2:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc_idx  = 0;
    string      tag      = "reset";

    morsecode_tx_controller #(
        .UNIT_CYCLES (UNIT),
        .MAX_LEN     (MLEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len_in     (len_in),
        .pattern_in (pattern_in),
        .morse_out  (morse_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: one expected {morse,busy,done} per clock while the trace is pending
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            cyc_idx++;
            checks++;
            if ({morse_out, busy, done} !== e) begin
                failures++;
                $display("FAIL %s cycle %0d: got morse/busy/done=%b expected %b",
                         tag, cyc_idx, {morse_out, busy, done}, e);
            end
        end
    end

    task automatic push(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Tail of a letter after its last mark: optional letter gap, then done
    task automatic push_end();
`ifdef MORSE_LETTER_GAP_EN
        push(3'b010, 12);
`endif
        push(3'b001, 1);
    endtask

    task automatic push_letter_a();
        push(3'b110, 4);
        push(3'b010, 4);
        push(3'b110, 12);
        push_end();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: %0d entries left, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drive start before edge 0 with the given letter; cycle index restarts at 1
    task automatic issue(input string name, input logic [2:0] len, input logic [MLEN-1:0] pat);
        @(negedge clk);
        #1;
        tag        = name;
        cyc_idx    = 0;
        len_in     = len;
        pattern_in = pat;
        start      = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        len_in     = '0;
        pattern_in = '0;
        push(3'b000, 3);
        drain();
        @(negedge clk);
        #1 reset = 1'b1;

        // 'A': dot, space, dash
        issue("letter_A", 3'd2, 4'b0010);
        push_letter_a();
        push(3'b000, 2);
        @(posedge clk); #1 start = 1'b0;
        drain();

        // 'E': single dot
        issue("letter_E", 3'd1, 4'b0000);
        push(3'b110, 4);
        push_end();
        push(3'b000, 2);
        @(posedge clk); #1 start = 1'b0;
        drain();

        // Empty letter: immediate done, never busy
        issue("len_zero", 3'd0, 4'b1111);
        push(3'b001, 1);
        push(3'b000, 3);
        @(posedge clk); #1 start = 1'b0;
        drain();

        // Over-long length clamps to 4 dashes
        issue("clamp_len7", 3'd7, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            push(3'b110, 12);
            push(3'b010, 4);
        end
        push(3'b110, 12);
        push_end();
        push(3'b000, 2);
        @(posedge clk); #1 start = 1'b0;
        drain();

        // Start and pattern change while busy are ignored
        issue("ignore_start", 3'd2, 4'b0010);
        push_letter_a();
        push(3'b000, 2);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start      = 1'b1;
        pattern_in = 4'b1111;
        len_in     = 3'd3;
        @(posedge clk); #1 start = 1'b0;
        drain();

        // Start held: second 'E' begins after a single idle cycle
        issue("held_start", 3'd1, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            push(3'b110, 4);
            push_end();
            push(3'b000, 1);
        end
        push(3'b000, 2);
`ifdef MORSE_LETTER_GAP_EN
        repeat (19) @(posedge clk);
`else
        repeat (7) @(posedge clk);
`endif
        #1 start = 1'b0;
        drain();

        // Reset during cycle 10 of 'A': outputs drop at once, no done
        issue("reset_mid", 3'd2, 4'b0010);
        push(3'b110, 4);
        push(3'b010, 4);
        push(3'b110, 1);
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        push(3'b000, 8);
        #1;
        checks++;
        if ({morse_out, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async: got morse/busy/done=%b expected 000",
                     {morse_out, busy, done});
        end
        drain();
        @(negedge clk);
        #1 reset = 1'b1;

        // Clean letter after reset release
        issue("after_reset", 3'd2, 4'b0010);
        push_letter_a();
        push(3'b000, 2);
        @(posedge clk); #1 start = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_morsecode_tx_controller
